fetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the MIPS core: owns the fetch PC, issues reads to the synchronous instruction memory, and buffers returned instructions with their PCs in a DEPTH-entry queue drained by decode through a valid/ready handshake. Branch/jump redirects from execute flush the queue and any in-flight read. This replaces the fixed pc_reg/pcplus4 fetch path so that decode stalls no longer gate the PC directly.

---
 rtl/fetch_queue_if.sv | 40 ++++
 rtl/fetch_queue.sv | 133 +++++++++++++
 tb/tb_fetch_queue.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch-side bus bundle: instruction-memory read port, redirect input and the
// decode-facing queue head. master = fetch_queue, slave = memory/decode side.
interface fetch_queue_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_inst;
  logic [ADDR_W-1:0] out_pc;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  redirect,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_inst,
    output out_pc
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output redirect,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_inst,
    input  out_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: fetch PC, 1-cycle imem reads, DEPTH-entry decode queue.
// Optional FETCH_QUEUE_JUMP_PREDECODE_EN redirects fetch on j/jal as they are pushed.
module fetch_queue #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  fetch_queue_if.master          bus,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  if (ADDR_W < 28) begin : g_chk_addr
    $error("fetch_queue: ADDR_W must be at least 28");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
    $error("fetch_queue: DEPTH must be a power of two and at least 2");
  end
`ifdef FETCH_QUEUE_JUMP_PREDECODE_EN
  if (DATA_W < 32) begin : g_chk_data
    $error("fetch_queue: jump predecode needs DATA_W of at least 32");
  end
`endif

  // kill only matters while a read is in flight, so inflight/kill fold into one slot state.
  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_LIVE,
    SLOT_DEAD
  } slot_e;

  slot_e             slot_q, slot_d;
  logic [ADDR_W-1:0] fpc_q, fpc_d;
  logic [ADDR_W-1:0] inflight_pc_q;
  logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic [CW:0]       occupancy;
  logic              req, push, pop;

  logic [DATA_W-1:0] inst_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];

  always_comb begin
    occupancy = {1'b0, count_q} + (CW+1)'(slot_q != SLOT_IDLE);
    req       = rst && !bus.redirect && (occupancy < (CW+1)'(DEPTH));
    push      = (slot_q == SLOT_LIVE) && !bus.redirect;
    pop       = (count_q != '0) && bus.out_ready && !bus.redirect;
  end

`ifdef FETCH_QUEUE_JUMP_PREDECODE_EN
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] jump_target;
  logic              jump_hit;

  always_comb begin
    seq_pc            = inflight_pc_q + ADDR_W'(4);
    jump_target       = seq_pc;
    jump_target[27:0] = {bus.imem_rdata[25:0], 2'b00};
    jump_hit          = push && (bus.imem_rdata[31:26] == 6'b000010 ||
                                 bus.imem_rdata[31:26] == 6'b000011);
  end
`endif

  always_comb begin
    slot_d  = SLOT_IDLE;
    fpc_d   = fpc_q;
    count_d = count_q;
    if (bus.redirect) begin
      fpc_d   = bus.redirect_pc;
      count_d = '0;
    end else begin
      if (req) begin
        fpc_d  = fpc_q + ADDR_W'(4);
        slot_d = SLOT_LIVE;
      end
`ifdef FETCH_QUEUE_JUMP_PREDECODE_EN
      // The sequential read issued alongside a taken jump is already wrong-path.
      if (jump_hit) begin
        fpc_d = jump_target;
        if (req) slot_d = SLOT_DEAD;
      end
`endif
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_q        <= SLOT_IDLE;
      fpc_q         <= RESET_PC;
      inflight_pc_q <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      slot_q  <= slot_d;
      fpc_q   <= fpc_d;
      count_q <= count_d;
      if (req) inflight_pc_q <= fpc_q;
      if (bus.redirect) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr_q] <= bus.imem_rdata;
      pc_mem[wr_ptr_q]   <= inflight_pc_q;
    end
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = fpc_q;
  assign bus.out_valid = (count_q != '0);
  assign bus.out_inst  = inst_mem[rd_ptr_q];
  assign bus.out_pc    = pc_mem[rd_ptr_q];
  assign count         = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed stimulus, in-order stream model on the decode side,
// plus a second instance with RESET_PC near the top of the address space.
module tb_fetch_queue;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_en;
  logic [2:0]  count, w_count;
  logic        req_d;
  logic [31:0] exp_pc;
  logic [31:0] delivered [$];
  logic [31:0] wrap_pc   [3];
  logic [31:0] wrap_inst [3];
  int          wrap_n    = 0;
  int          n_checks  = 0;
  int          n_errors  = 0;
  int          hs_count  = 0;

  always #5 clk = ~clk;

  fetch_queue_if #(.ADDR_W(32), .DATA_W(32)) bus_main ();
  fetch_queue_if #(.ADDR_W(32), .DATA_W(32)) bus_wrap ();

  fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst(rst), .bus(bus_main), .count(count)
  );

  fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst(rst), .bus(bus_wrap), .count(w_count)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (jump_en && a == 32'h0000_0008) return 32'h0800_0010;
    return 32'h2008_0000 + ((a >> 2) + 32'd1);
  endfunction

  // Next PC in program order as decode should see it.
  function automatic logic [31:0] model_next(input logic [31:0] pc);
`ifdef FETCH_QUEUE_JUMP_PREDECODE_EN
    logic [31:0] w;
    logic [31:0] seq;
    w   = mem_word(pc);
    seq = pc + 32'd4;
    if (w[31:26] == 6'b000010 || w[31:26] == 6'b000011) return {seq[31:28], w[25:0], 2'b00};
    return seq;
`else
    return pc + 32'd4;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Synchronous instruction memory; unrequested cycles return junk.
  always @(posedge clk) begin
    bus_main.imem_rdata <= bus_main.imem_req ? mem_word(bus_main.imem_addr) : 32'hDEAD_BEEF;
    bus_wrap.imem_rdata <= bus_wrap.imem_req ? mem_word(bus_wrap.imem_addr) : 32'hDEAD_BEEF;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) req_d <= 1'b0;
    else      req_d <= bus_main.imem_req;
  end

  always @(negedge clk) begin
    if (!rst) begin
      exp_pc = 32'h0;
    end else begin
      check("valid_vs_count", 64'(bus_main.out_valid), 64'(count != 3'd0));
      check("count_bound", 64'(count <= 3'(DEPTH)), 64'd1);
      check("req_rule", 64'(bus_main.imem_req),
            64'(!bus_main.redirect && (({1'b0, count} + {3'b000, req_d}) < 4'(DEPTH))));
      if (bus_main.redirect) begin
        exp_pc = bus_main.redirect_pc;
      end else if (bus_main.out_valid && bus_main.out_ready) begin
        check("stream_pc", 64'(bus_main.out_pc), 64'(exp_pc));
        check("stream_inst", 64'(bus_main.out_inst), 64'(mem_word(exp_pc)));
        delivered.push_back(bus_main.out_pc);
        hs_count++;
        exp_pc = model_next(exp_pc);
      end
    end
  end

  always @(negedge clk) begin
    if (rst && bus_wrap.out_valid && wrap_n < 3) begin
      wrap_pc[wrap_n]   = bus_wrap.out_pc;
      wrap_inst[wrap_n] = bus_wrap.out_inst;
      wrap_n++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int first, lat, hs0, n;
    logic [31:0] exp5 [5];

    rst                  = 1'b1;
    jump_en              = 1'b0;
    bus_main.out_ready   = 1'b0;
    bus_main.redirect    = 1'b0;
    bus_main.redirect_pc = 32'h0;
    bus_wrap.out_ready   = 1'b1;
    bus_wrap.redirect    = 1'b0;
    bus_wrap.redirect_pc = 32'h0;
    #2 rst = 1'b0;
    tick();
    tick();

    check("rst_imem_req", 64'(bus_main.imem_req), 64'd0);
    check("rst_imem_addr", 64'(bus_main.imem_addr), 64'h0);
    check("rst_out_valid", 64'(bus_main.out_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_wrap_addr", 64'(bus_wrap.imem_addr), 64'hFFFF_FFF8);

    // Fill with decode stalled
    rst = 1'b1;
    #1;
    check("first_req", 64'(bus_main.imem_req), 64'd1);
    check("first_addr", 64'(bus_main.imem_addr), 64'h0);
    first = -1;
    for (int k = 0; k < 12; k++) begin
      if (first < 0 && bus_main.out_valid) first = k;
      if (k == 5) check("hold_pc_mid", 64'(bus_main.out_pc), 64'h0);
      tick();
    end
    check("first_valid_cycle", 64'(first), 64'd2);
    check("full_count", 64'(count), 64'd4);
    check("full_req", 64'(bus_main.imem_req), 64'd0);
    check("full_head_pc", 64'(bus_main.out_pc), 64'h0);
    check("full_head_inst", 64'(bus_main.out_inst), 64'h2008_0001);

    // Release
    bus_main.out_ready = 1'b1;
    #1;
    check("release_req", 64'(bus_main.imem_req), 64'd0);
    tick();
    check("after_pop_count", 64'(count), 64'd3);
    check("after_pop_req", 64'(bus_main.imem_req), 64'd1);
    check("after_pop_addr", 64'(bus_main.imem_addr), 64'h10);
    hs0 = hs_count;
    for (int k = 0; k < 8; k++) tick();
    check("throughput", 64'(hs_count - hs0), 64'd8);

    check("wrap_captured", 64'(wrap_n), 64'd3);
    check("wrap_pc0", 64'(wrap_pc[0]), 64'hFFFF_FFF8);
    check("wrap_pc1", 64'(wrap_pc[1]), 64'hFFFF_FFFC);
    check("wrap_pc2", 64'(wrap_pc[2]), 64'h0000_0000);
    check("wrap_inst0", 64'(wrap_inst[0]), 64'h6007_FFFF);
    check("wrap_inst1", 64'(wrap_inst[1]), 64'h6008_0000);
    check("wrap_inst2", 64'(wrap_inst[2]), 64'h2008_0001);
    check("wrap_count_bound", 64'(w_count <= 3'(DEPTH)), 64'd1);

    // Redirect with three queued and one read in flight
    bus_main.out_ready = 1'b0;
    n = 0;
    while (count != 3'd3 && n < 10) begin
      tick();
      n++;
    end
    check("count3_reached", 64'(count), 64'd3);
    check("inflight_at_redirect", 64'(req_d), 64'd1);
    bus_main.redirect    = 1'b1;
    bus_main.redirect_pc = 32'h40;
    bus_main.out_ready   = 1'b1;
    #1;
    check("redirect_no_req", 64'(bus_main.imem_req), 64'd0);
    tick();
    bus_main.redirect = 1'b0;
    #1;
    check("post_redirect_count", 64'(count), 64'd0);
    check("post_redirect_valid", 64'(bus_main.out_valid), 64'd0);
    check("post_redirect_addr", 64'(bus_main.imem_addr), 64'h40);
    check("post_redirect_req", 64'(bus_main.imem_req), 64'd1);
    lat = 1;
    while (!bus_main.out_valid && lat < 8) begin
      tick();
      lat++;
    end
    check("redirect_latency", 64'(lat), 64'd3);
    check("redirect_head_pc", 64'(bus_main.out_pc), 64'h40);
    check("redirect_head_inst", 64'(bus_main.out_inst), 64'h2008_0011);

    // Back-to-back redirects: the second target wins
    for (int k = 0; k < 4; k++) tick();
    bus_main.redirect    = 1'b1;
    bus_main.redirect_pc = 32'h100;
    tick();
    bus_main.redirect_pc = 32'h80;
    #1;
    check("b2b_no_req", 64'(bus_main.imem_req), 64'd0);
    tick();
    bus_main.redirect = 1'b0;
    #1;
    check("b2b_count", 64'(count), 64'd0);
    check("b2b_addr", 64'(bus_main.imem_addr), 64'h80);
    lat = 1;
    while (!bus_main.out_valid && lat < 8) begin
      tick();
      lat++;
    end
    check("b2b_latency", 64'(lat), 64'd3);
    check("b2b_head_pc", 64'(bus_main.out_pc), 64'h80);

    // Asynchronous reset mid-stream with a read outstanding
    for (int k = 0; k < 6; k++) tick();
    check("inflight_before_reset", 64'(req_d), 64'd1);
    rst = 1'b0;
    #1;
    check("async_rst_req", 64'(bus_main.imem_req), 64'd0);
    check("async_rst_addr", 64'(bus_main.imem_addr), 64'h0);
    check("async_rst_valid", 64'(bus_main.out_valid), 64'd0);
    check("async_rst_count", 64'(count), 64'd0);
    jump_en = 1'b1;
    delivered.delete();
    tick();
    tick();
    rst = 1'b1;
    for (int k = 0; k < 14; k++) tick();
`ifdef FETCH_QUEUE_JUMP_PREDECODE_EN
    exp5 = '{32'h0, 32'h4, 32'h8, 32'h40, 32'h44};
`else
    exp5 = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
`endif
    check("delivered_enough", 64'(delivered.size() >= 5), 64'd1);
    for (int i = 0; i < 5 && i < delivered.size(); i++)
      check($sformatf("restart_pc%0d", i), 64'(delivered[i]), 64'(exp5[i]));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
